// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer; Clear flushes to BUBBLE.
// Optional stall/flush performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 96,
  parameter logic [WIDTH-1:0]  BUBBLE    = {WIDTH{1'b0}},
  parameter int unsigned       CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // EMPTY: (main_v,skid_v)=(0,0), ONE: (1,0), FULL: (1,1)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state and storage; Clear overrides any push/pop in the same cycle
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Clear) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            main_d  = BUBBLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Saturating counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != {CNT_WIDTH{1'b1}}))
        stall_q <= stall_q + CNT_WIDTH'(1);
      if (Clear && (flush_q != {CNT_WIDTH{1'b1}}))
        flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg with WIDTH=32, BUBBLE=NOP, CNT_WIDTH=4.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] NOP = 32'h0000_0013;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          Clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(NOP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Clear(Clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eov;
    logic [W-1:0] eod;
    logic         eir;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic clr, logic iv, logic [W-1:0] d, logic ordy,
                              logic eov, logic [W-1:0] eod, logic eir);
    vec_t v;
    v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic iv, input logic [W-1:0] d, input logic ordy);
    Clear = clr; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    // Table: expected outputs are those seen in the cycle the row's inputs are applied
    // streaming
    vq.push_back(mk(0, 1, 32'h01, 1, 0, NOP, 1));
    for (int i = 2; i <= 8; i++)
      vq.push_back(mk(0, 1, W'(i), 1, 1, W'(i - 1), 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 1, 32'h08, 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 0, NOP, 1));
    // back-pressure into skid, then drain in order
    vq.push_back(mk(0, 1, 32'h10, 0, 0, NOP, 1));
    vq.push_back(mk(0, 1, 32'h11, 0, 1, 32'h10, 1));
    vq.push_back(mk(0, 1, 32'h12, 0, 1, 32'h10, 0));
    vq.push_back(mk(0, 1, 32'h12, 0, 1, 32'h10, 0));
    vq.push_back(mk(0, 1, 32'h12, 1, 1, 32'h10, 0));
    vq.push_back(mk(0, 1, 32'h12, 1, 1, 32'h11, 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 1, 32'h12, 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 0, NOP, 1));
    // flush priority from FULL, then held Clear
    vq.push_back(mk(0, 1, 32'h20, 0, 0, NOP, 1));
    vq.push_back(mk(0, 1, 32'h21, 0, 1, 32'h20, 1));
    vq.push_back(mk(1, 1, 32'h22, 1, 1, 32'h20, 0));
    vq.push_back(mk(0, 0, 32'h00, 1, 0, NOP, 1));
    vq.push_back(mk(1, 1, 32'h23, 1, 0, NOP, 1));
    vq.push_back(mk(1, 1, 32'h24, 1, 0, NOP, 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 0, NOP, 1));
    // empty pop
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 32'h00, 1, 0, NOP, 1));
    vq.push_back(mk(0, 1, 32'h30, 1, 0, NOP, 1));
    vq.push_back(mk(0, 0, 32'h00, 1, 1, 32'h30, 1));
    vq.push_back(mk(0, 0, 32'h00, 0, 0, NOP, 1));

    reset = 1'b0;
    drive(0, 0, '0, 0);
    step();
    step();
    chk("rst_ov", W'(out_valid), W'(1'b0));
    chk("rst_od", out_data, NOP);
    chk("rst_ir", W'(in_ready), W'(1'b1));
    chk("rst_stall", W'(stall_cnt), W'(0));
    chk("rst_flush", W'(flush_cnt), W'(0));
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      chk($sformatf("v%0d_ov", i), W'(out_valid), W'(vq[i].eov));
      chk($sformatf("v%0d_od", i), out_data, vq[i].eod);
      chk($sformatf("v%0d_ir", i), W'(in_ready), W'(vq[i].eir));
      drive(vq[i].clr, vq[i].iv, vq[i].d, vq[i].ordy);
      step();
    end

    // Stalls so far: four cycles with out_valid=1, out_ready=0; three Clear cycles
    chk("cnt_stall_tab", W'(stall_cnt), PERF ? W'(4) : W'(0));
    chk("cnt_flush_tab", W'(flush_cnt), PERF ? W'(3) : W'(0));

    // Long stall: data must stay stable and stall_cnt must saturate
    drive(0, 1, 32'h40, 0);
    step();
    drive(0, 0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("hold%0d_od", i), out_data, 32'h40);
      step();
    end
    chk("hold_ov", W'(out_valid), W'(1'b1));
    chk("cnt_stall_sat", W'(stall_cnt), PERF ? W'(15) : W'(0));
    chk("cnt_flush_keep", W'(flush_cnt), PERF ? W'(3) : W'(0));

    // Fill to FULL, then reset asynchronously mid-cycle
    drive(0, 1, 32'h41, 0);
    step();
    chk("full_ir", W'(in_ready), W'(1'b0));
    drive(0, 1, 32'h42, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ov", W'(out_valid), W'(1'b0));
    chk("arst_ir", W'(in_ready), W'(1'b1));
    chk("arst_od", out_data, NOP);
    chk("arst_stall", W'(stall_cnt), W'(0));
    chk("arst_flush", W'(flush_cnt), W'(0));
    drive(0, 0, '0, 1);
    step();
    reset = 1'b1;
    drive(0, 1, 32'hAA, 1);
    step();
    chk("post_rst_ov", W'(out_valid), W'(1'b1));
    chk("post_rst_od", out_data, 32'hAA);
    drive(0, 0, '0, 1);
    step();
    chk("post_rst_drain_ov", W'(out_valid), W'(1'b0));
    chk("post_rst_drain_od", out_data, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
